trb_pkt_dispatch: RTL and testbench

//  Packet-level dispatcher between the clk_st-side read port of the bus input FIFO and NUM_TURBO bus2st_turbo lanes.

---
 rtl/trb_pkg.sv | 18 +
 rtl/trb_rr_pick.sv | 29 ++
 rtl/trb_pkt_dispatch.sv | 126 ++++++++++++
 tb/tb_trb_pkt_dispatch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trb_pkg.sv
// Shared constants and types for the turbo packet dispatcher.
// The optional rdreq spacing feature is enabled with TRB_DISP_GAP_EN.
package trb_pkg;

    localparam int BUS             = 534;
    localparam int NUM_TURBO       = 2;
    localparam int NUM_BUS_PER_PKT = 25;
    localparam int GAP_CYC         = 1;

    localparam int LANE_W = (NUM_TURBO > 1) ? $clog2(NUM_TURBO) : 1;
    localparam int CNT_W  = 9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } disp_state_e;

endpackage

// File: rtl/trb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N. found_o is low when no request is asserted.
module trb_rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        idx_o   = '0;
        found_o = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!found_o && req_i[W'(j)]) begin
                found_o = 1'b1;
                idx_o   = W'(j);
            end
        end
    end

endmodule

// File: rtl/trb_pkt_dispatch.sv
// Packet dispatcher from the bus FIFO read port to NUM_TURBO turbo lanes.
// Define TRB_DISP_GAP_EN to enforce GAP_CYC idle cycles between rdreqs.
module trb_pkt_dispatch
    import trb_pkg::*;
(
    input  logic                 clk_st,
    input  logic                 rst,
    input  logic                 ff_rdempty,
    input  logic [BUS-1:0]       ff_q,
    output logic                 ff_rdreq,
    input  logic [NUM_TURBO-1:0] lane_ready,
    output logic [NUM_TURBO-1:0] lane_en,
    output logic [BUS-1:0]       lane_data,
    output logic                 pkt_done,
    output logic [3:0]           pkt_lane
);

    disp_state_e          state_q,    state_d;
    logic [LANE_W-1:0]    cur_q,      cur_d;
    logic [LANE_W-1:0]    rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [NUM_TURBO-1:0] lane_en_q,  lane_en_d;
    logic                 pkt_done_q, pkt_done_d;
    logic [3:0]           pkt_lane_q, pkt_lane_d;

    logic [LANE_W-1:0]    pick_idx;
    logic                 pick_found;
    logic [LANE_W-1:0]    cur_inc;
    logic                 last_word;
    logic                 gap_ok;

    trb_rr_pick #(
        .N (NUM_TURBO),
        .W (LANE_W)
    ) u_pick (
        .req_i   (lane_ready),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

`ifdef TRB_DISP_GAP_EN
    // Cycles since the last rdreq, saturating so a long idle never wraps back to "too soon".
    logic [1:0] gap_cnt_q, gap_cnt_d;

    assign gap_ok = (gap_cnt_q >= 2'(GAP_CYC));

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (ff_rdreq)                gap_cnt_d = 2'd0;
        else if (gap_cnt_q != 2'd3)  gap_cnt_d = gap_cnt_q + 2'd1;
    end

    always_ff @(posedge clk_st) begin
        if (rst) gap_cnt_q <= 2'd3;
        else     gap_cnt_q <= gap_cnt_d;
    end
`else
    assign gap_ok = 1'b1;
`endif

    assign ff_rdreq  = (state_q == XFER) && !ff_rdempty && lane_ready[cur_q] && gap_ok;
    assign last_word = (word_cnt_q == CNT_W'(NUM_BUS_PER_PKT - 1));
    assign cur_inc   = (cur_q == LANE_W'(NUM_TURBO - 1)) ? '0 : cur_q + LANE_W'(1);

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rr_ptr_d   = rr_ptr_q;
        word_cnt_d = word_cnt_q;
        pkt_lane_d = pkt_lane_q;
        lane_en_d  = '0;
        pkt_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    cur_d      = pick_idx;
                    pkt_lane_d = 4'(pick_idx);
                    state_d    = XFER;
                end
            end
            XFER: begin
                // The lane stays locked until the packet's last word is read.
                if (ff_rdreq) begin
                    lane_en_d[cur_q] = 1'b1;
                    if (last_word) begin
                        word_cnt_d = '0;
                        rr_ptr_d   = cur_inc;
                        pkt_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_st) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            rr_ptr_q   <= '0;
            word_cnt_q <= '0;
            lane_en_q  <= '0;
            pkt_done_q <= 1'b0;
            pkt_lane_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rr_ptr_q   <= rr_ptr_d;
            word_cnt_q <= word_cnt_d;
            lane_en_q  <= lane_en_d;
            pkt_done_q <= pkt_done_d;
            pkt_lane_q <= pkt_lane_d;
        end
    end

    assign lane_en   = lane_en_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_lane  = pkt_lane_q;
    assign lane_data = ff_q;

endmodule

// File: tb/tb_trb_pkt_dispatch.sv
// Directed self-checking bench for trb_pkt_dispatch with a behavioural FIFO model.
// Spacing expectations follow TRB_DISP_GAP_EN when it is defined.
module tb_trb_pkt_dispatch;
    import trb_pkg::*;

`ifdef TRB_DISP_GAP_EN
    localparam int SPC = GAP_CYC + 1;
`else
    localparam int SPC = 1;
`endif

    logic                 clk_st = 1'b0;
    logic                 rst;
    logic                 ff_rdempty;
    logic [BUS-1:0]       ff_q;
    logic                 ff_rdreq;
    logic [NUM_TURBO-1:0] lane_ready;
    logic [NUM_TURBO-1:0] lane_en;
    logic [BUS-1:0]       lane_data;
    logic                 pkt_done;
    logic [3:0]           pkt_lane;

    always #5 clk_st = ~clk_st;

    trb_pkt_dispatch dut (
        .clk_st     (clk_st),
        .rst        (rst),
        .ff_rdempty (ff_rdempty),
        .ff_q       (ff_q),
        .ff_rdreq   (ff_rdreq),
        .lane_ready (lane_ready),
        .lane_en    (lane_en),
        .lane_data  (lane_data),
        .pkt_done   (pkt_done),
        .pkt_lane   (pkt_lane)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int avail, next_word, issued, cyc, pkt_words;
    logic                 samp_rdreq;
    logic [NUM_TURBO-1:0] samp_lane_en;
    int cap_word[$];
    int cap_lane[$];
    int cap_done[$];
    int cap_cyc[$];
    int cap_plane[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NUM_TURBO-1:0] v);
        int r = -1;
        for (int i = 0; i < NUM_TURBO; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic clear_caps();
        cap_word.delete();
        cap_lane.delete();
        cap_done.delete();
        cap_cyc.delete();
        cap_plane.delete();
    endtask

    task automatic add_words(input int n);
        avail      = avail + n;
        ff_rdempty = (avail == 0);
    endtask

    // One clock: sample and check at the falling edge, advance the FIFO model after the rising edge.
    task automatic cycle();
        @(negedge clk_st);
        samp_rdreq   = ff_rdreq;
        samp_lane_en = lane_en;
        check("lane_en_onehot", 32'($onehot0(lane_en)), 32'd1);
        check("rdreq_while_empty", 32'(ff_rdreq & ff_rdempty), 32'd0);
        if (rst) begin
            pkt_words = 0;
        end else begin
            check("done_without_en", 32'(pkt_done & (lane_en == '0)), 32'd0);
            if (lane_en != '0) begin
                cap_word.push_back(int'(lane_data[15:0]));
                cap_lane.push_back(onehot_idx(lane_en));
                cap_done.push_back(int'(pkt_done));
                cap_cyc.push_back(cyc);
                cap_plane.push_back(int'(pkt_lane));
                pkt_words++;
                if (pkt_done) begin
                    check("words_per_pkt", pkt_words, 25);
                    pkt_words = 0;
                end
            end
        end
        @(posedge clk_st);
        #1;
        cyc++;
        if (samp_rdreq) begin
            ff_q = BUS'(next_word);
            next_word++;
            avail--;
            issued++;
        end
        ff_rdempty = (avail == 0);
    endtask

    task automatic do_reset(input logic [NUM_TURBO-1:0] ready);
        rst        = 1'b1;
        lane_ready = ready;
        avail      = 0;
        next_word  = 0;
        issued     = 0;
        ff_rdempty = 1'b1;
        cycle();
        cycle();
        check("rst_lane_en", 32'(lane_en), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_pkt_lane", 32'(pkt_lane), 32'd0);
        check("rst_rdreq", 32'(ff_rdreq), 32'd0);
        rst       = 1'b0;
        pkt_words = 0;
        clear_caps();
    endtask

    task automatic run_until_caps(input int n, input int max_cyc);
        int k = 0;
        while (cap_word.size() < n && k < max_cyc) begin
            cycle();
            k++;
        end
        check("capture_count", cap_word.size(), n);
    endtask

    task automatic run_until_issued(input int n, input int max_cyc);
        int k = 0;
        while (issued < n && k < max_cyc) begin
            cycle();
            k++;
        end
        check("issued_count", issued, n);
    endtask

    initial begin
        rst        = 1'b1;
        ff_rdempty = 1'b1;
        ff_q       = '0;
        lane_ready = '0;
        avail      = 0;
        next_word  = 0;
        issued     = 0;
        cyc        = 0;
        pkt_words  = 0;

        // Two full packets with both lanes ready: lane 0 then lane 1.
        do_reset(2'b11);
        add_words(50);
        run_until_caps(50, 400);
        for (int k = 0; k < cap_word.size(); k++) begin
            check("t1_lane", cap_lane[k], (k < 25) ? 0 : 1);
            check("t1_word", cap_word[k], k);
            check("t1_done", cap_done[k], (k == 24 || k == 49) ? 1 : 0);
            check("t1_pkt_lane", cap_plane[k], (k < 25) ? 0 : 1);
            if (k > 0) check("t1_spacing", cap_cyc[k] - cap_cyc[k-1], (k == 25) ? 2 : SPC);
        end
        if (cap_word.size() >= 25) check("t1_pkt_span", cap_cyc[24] - cap_cyc[0], 24 * SPC);

        // Only lane 1 ready twice; both ready during the second packet -> third goes to lane 0.
        do_reset(2'b10);
        add_words(75);
        run_until_caps(30, 300);
        lane_ready = 2'b11;
        run_until_caps(75, 400);
        for (int k = 0; k < cap_word.size(); k++) begin
            check("t2_lane", cap_lane[k], (k < 50) ? 1 : 0);
            check("t2_word", cap_word[k], k);
            check("t2_done", cap_done[k], (k == 24 || k == 49 || k == 74) ? 1 : 0);
        end

        // Lane 0 not ready for 5 cycles after word 10 is requested.
        do_reset(2'b11);
        add_words(25);
        run_until_issued(10, 100);
        lane_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_stall_rdreq", 32'(samp_rdreq), 32'd0);
        end
        lane_ready = 2'b11;
        run_until_caps(25, 200);
        for (int k = 0; k < cap_word.size(); k++) begin
            check("t3_lane", cap_lane[k], 0);
            check("t3_word", cap_word[k], k);
            check("t3_done", cap_done[k], (k == 24) ? 1 : 0);
        end
        if (cap_word.size() >= 11) check("t3_stall_gap", cap_cyc[10] - cap_cyc[9], 6);

        // FIFO runs dry after 7 words for 3 cycles.
        do_reset(2'b11);
        add_words(7);
        run_until_issued(7, 100);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t4_empty_rdreq", 32'(samp_rdreq), 32'd0);
            if (i > 0) check("t4_empty_lane_en", 32'(samp_lane_en), 32'd0);
        end
        add_words(18);
        run_until_caps(25, 200);
        for (int i = 0; i < 3; i++) cycle();
        check("t4_no_extra_words", cap_word.size(), 25);
        for (int k = 0; k < cap_word.size(); k++) begin
            check("t4_lane", cap_lane[k], 0);
            check("t4_word", cap_word[k], k);
            check("t4_done", cap_done[k], (k == 24) ? 1 : 0);
        end

        // Reset after word 12 is requested; word 12 is popped on the reset edge itself.
        do_reset(2'b11);
        add_words(50);
        run_until_issued(12, 100);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_caps();
        cycle();
        check("t5_lane_en_after_rst", 32'(samp_lane_en), 32'd0);
        check("t5_rdreq_after_rst", 32'(samp_rdreq), 32'd0);
        check("t5_pkt_done_after_rst", 32'(pkt_done), 32'd0);
        check("t5_pkt_lane_after_rst", 32'(pkt_lane), 32'd0);
        run_until_caps(26, 300);
        for (int k = 0; k < cap_word.size(); k++) begin
            check("t5_lane", cap_lane[k], (k < 25) ? 0 : 1);
            check("t5_word", cap_word[k], 13 + k);
            check("t5_done", cap_done[k], (k == 24) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
